// File: rtl/coincidence_scan_sequencer.sv
// coincidence_scan_sequencer: arms the coincidence recorder, sweeps every (address, channel) bin and streams the sums.
// Optional rising-edge peak search and coincidence set-up is built in when COINCIDENCE_SCAN_PEAK_EN is defined.
module coincidence_scan_sequencer #(
    parameter int CHANNEL_COUNT        = 2,
    parameter int SAMPLE_COUNTER_WIDTH = 8,
    parameter int SAMPLES_PER_SCAN     = 200,
    parameter int SUM_WIDTH            = 10,
    parameter int RB_HOLDOFF           = 8,
    parameter int TIMEOUT_WIDTH        = 24,
    parameter int PEAK_CHANNEL         = 0,
    localparam int MW  = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1,
    localparam int SCW = SAMPLE_COUNTER_WIDTH,
    localparam int SW  = SUM_WIDTH
) (
    input  logic                  sysClk,
    input  logic                  sysResetN,
    input  logic                  sysCsrStrobe,
    input  logic [31:0]           sysGPIO_OUT,
    output logic [31:0]           sysStatus,
    output logic                  recCsrStrobe,
    output logic [31:0]           recGPIO_OUT,
    input  logic [31:0]           recCsr,
    output logic                  scanValid,
    input  logic                  scanReady,
    output logic [MW+SCW+SW-1:0]  scanData,
    output logic                  scanLast
);
`ifdef COINCIDENCE_SCAN_PEAK_EN
    localparam bit PEAK_EN = 1'b1;
`else
    localparam bit PEAK_EN = 1'b0;
`endif
    localparam int TW = TIMEOUT_WIDTH;
    localparam int HW = $clog2(RB_HOLDOFF + 2);
    localparam logic [MW-1:0]  LAST_MUX  = MW'(CHANNEL_COUNT - 1);
    localparam logic [MW-1:0]  PEAK_MUX  = MW'(PEAK_CHANNEL);
    localparam logic [SCW-1:0] LAST_ADDR = SCW'(SAMPLES_PER_SCAN - 1);
    localparam logic [HW-1:0]  HOLD      = HW'(RB_HOLDOFF);

    typedef enum logic [3:0] {
        IDLE, ARM, WAIT_BUSY, WAIT_DONE, REQ, WAIT_RB, EMIT, PK_SET, PK_WAIT, PK_ALIGN, DONE
    } state_t;

    state_t         state_q, state_d;
    logic [MW-1:0]  mux_q, mux_d;
    logic [SCW-1:0] addr_q, addr_d, paddr_q, paddr_d;
    logic [SW-1:0]  sum_q, sum_d, prev_q, prev_d, thr_q, thr_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           pv_q, pv_d, done_q, done_d, terr_q, terr_d, strobe_q, strobe_d;
    logic [31:0]    word_q, word_d, req_word, set_word;
    logic           abort, start, echo_ok, last, crossing, unused_ok;

    assign abort     = sysCsrStrobe && sysGPIO_OUT[30];
    assign start     = sysCsrStrobe && sysGPIO_OUT[31] && !sysGPIO_OUT[30];
    assign echo_ok   = recCsr[24+:MW] == mux_q && recCsr[SW+:SCW] == addr_q;
    assign last      = mux_q == LAST_MUX && addr_q == LAST_ADDR;
    assign crossing  = PEAK_EN && mux_q == PEAK_MUX && addr_q != '0 && !pv_q && prev_q < thr_q && sum_q >= thr_q;
    assign unused_ok = ^{sysGPIO_OUT, recCsr};

    always_comb begin
        state_d  = state_q;
        mux_d    = mux_q;
        addr_d   = addr_q;
        sum_d    = sum_q;
        prev_d   = prev_q;
        thr_d    = thr_q;
        paddr_d  = paddr_q;
        pv_d     = pv_q;
        done_d   = done_q;
        terr_d   = terr_q;
        hold_d   = hold_q;
        tmo_d    = tmo_q - TW'(1);
        req_word = '0;
        set_word = '0;
        case (state_q)
            IDLE: if (start) begin
                state_d = ARM;
                mux_d   = '0;
                addr_d  = '0;
                done_d  = 1'b0;
                terr_d  = 1'b0;
                pv_d    = 1'b0;
                paddr_d = '0;
            end
            ARM: begin
                state_d = WAIT_BUSY;
                tmo_d   = '1;
            end
            WAIT_BUSY: if (recCsr[31]) begin
                state_d = WAIT_DONE;
                tmo_d   = '1;
            end
            WAIT_DONE: if (!recCsr[31]) state_d = REQ;
            REQ: begin
                state_d = WAIT_RB;
                hold_d  = HOLD;
                tmo_d   = '1;
            end
            WAIT_RB: if (hold_q != '0) hold_d = hold_q - HW'(1);
                else if (echo_ok) begin
                    sum_d   = recCsr[0+:SW];
                    state_d = EMIT;
                end
            EMIT: if (scanReady) begin
                prev_d  = (PEAK_EN && mux_q == PEAK_MUX) ? sum_q : prev_q;
                pv_d    = pv_q || crossing;
                paddr_d = crossing ? addr_q : paddr_q;
                state_d = !last ? REQ : (PEAK_EN && pv_d) ? PK_SET : DONE;
                mux_d   = last ? mux_q : (mux_q == LAST_MUX) ? '0 : mux_q + MW'(1);
                addr_d  = (!last && mux_q == LAST_MUX) ? addr_q + SCW'(1) : addr_q;
            end
            PK_SET: begin
                state_d = PK_WAIT;
                hold_d  = HW'(1);
            end
            PK_WAIT: if (hold_q != '0) hold_d = hold_q - HW'(1);
                else state_d = PK_ALIGN;
            PK_ALIGN: state_d = DONE;
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Only the three recorder wait states can expire; a match on the final cycle still wins.
        if (state_d == state_q && state_q inside {WAIT_BUSY, WAIT_DONE, WAIT_RB} && tmo_q == '0) begin
            state_d = IDLE;
            terr_d  = 1'b1;
        end
        if (abort) begin
            state_d = IDLE;
            done_d  = done_q;
        end
        if (PEAK_EN && sysCsrStrobe && sysGPIO_OUT[29]) thr_d = sysGPIO_OUT[0+:SW];
        req_word[24+:MW] = mux_d;
        req_word[0+:SCW] = addr_d;
        set_word[30]     = 1'b1;
        set_word[0+:SCW] = paddr_d;
        strobe_d = state_d inside {ARM, REQ, PK_SET, PK_ALIGN};
        word_d   = state_d == ARM      ? 32'h8000_0000 :
                   state_d == REQ      ? req_word :
                   state_d == PK_SET   ? set_word :
                   state_d == PK_ALIGN ? 32'h2000_0000 : word_q;
    end

    always_ff @(posedge sysClk or negedge sysResetN) begin
        if (!sysResetN) begin
            state_q  <= IDLE;
            mux_q    <= '0;
            addr_q   <= '0;
            sum_q    <= '0;
            prev_q   <= '0;
            thr_q    <= SW'(1) << (SW - 1);
            paddr_q  <= '0;
            pv_q     <= 1'b0;
            done_q   <= 1'b0;
            terr_q   <= 1'b0;
            hold_q   <= '0;
            tmo_q    <= '0;
            strobe_q <= 1'b0;
            word_q   <= '0;
        end else begin
            state_q  <= state_d;
            mux_q    <= mux_d;
            addr_q   <= addr_d;
            sum_q    <= sum_d;
            prev_q   <= prev_d;
            thr_q    <= thr_d;
            paddr_q  <= paddr_d;
            pv_q     <= pv_d;
            done_q   <= done_d;
            terr_q   <= terr_d;
            hold_q   <= hold_d;
            tmo_q    <= tmo_d;
            strobe_q <= strobe_d;
            word_q   <= word_d;
        end
    end

    always_comb begin
        sysStatus         = '0;
        sysStatus[31]     = state_q != IDLE;
        sysStatus[30]     = done_q;
        sysStatus[29]     = terr_q;
        sysStatus[28]     = PEAK_EN && pv_q;
        sysStatus[0+:SCW] = PEAK_EN ? paddr_q : '0;
    end

    assign recCsrStrobe = strobe_q;
    assign recGPIO_OUT  = word_q;
    assign scanValid    = state_q == EMIT;
    assign scanData     = {mux_q, addr_q, sum_q};
    assign scanLast     = scanValid && last;
endmodule

// File: tb/tb_coincidence_scan_sequencer.sv
// tb_coincidence_scan_sequencer: recorder model plus scoreboard of expected stream beats.
module tb_coincidence_scan_sequencer;
    localparam logic [31:0] START = 32'h8000_0000;
    localparam logic [31:0] ABORT = 32'h4000_0000;

    logic        sysClk = 1'b0;
    logic        sysResetN, sysCsrStrobe, recCsrStrobe, scanValid, scanReady, scanLast;
    logic [31:0] sysGPIO_OUT, sysStatus, recGPIO_OUT;
    logic [31:0] recCsr = '0;
    logic [18:0] scanData;

    int checks = 0, failures = 0, beats = 0;
    int cyc = 0, start_cyc = -1000, echo_at = -1;
    int n_start = 0, n_read = 0, n_strobes = 0, n_b2b = 0;
    bit busy_en = 1'b1, stale_mode = 1'b0, peak_mode = 1'b0, prev_strobe = 1'b0;
    logic        req_mux;
    logic [7:0]  req_addr;
    logic [31:0] echo = '0;
    logic [31:0] other_w[$];
    int          other_c[$];
    logic [18:0] exp_data[$];
    bit          exp_last[$];

    coincidence_scan_sequencer #(.TIMEOUT_WIDTH(6)) dut (
        .sysClk(sysClk), .sysResetN(sysResetN), .sysCsrStrobe(sysCsrStrobe),
        .sysGPIO_OUT(sysGPIO_OUT), .sysStatus(sysStatus), .recCsrStrobe(recCsrStrobe),
        .recGPIO_OUT(recGPIO_OUT), .recCsr(recCsr), .scanValid(scanValid),
        .scanReady(scanReady), .scanData(scanData), .scanLast(scanLast)
    );

    always #5 sysClk = ~sysClk;

    function automatic logic [9:0] sum_of(int a, int m);
        if (peak_mode) return m == 0 ? (a < 42 ? 10'd3 : 10'd6) : 10'd9;
        return 10'((a * 5 + m * 77 + 3) % 1024);
    endfunction

    function automatic logic [31:0] pack(logic m, logic [7:0] a, logic [9:0] s);
        logic [31:0] r;
        r = '0;
        r[24] = m;
        r[10+:8] = a;
        r[0+:10] = s;
        return r;
    endfunction

    // Recorder: busy 2 cycles after start for 50 cycles; echo 4 cycles after a readback request.
    always @(negedge sysClk) begin
        cyc++;
        if (recCsrStrobe) begin
            n_strobes++;
            if (prev_strobe) n_b2b++;
            if (recGPIO_OUT == START) begin
                n_start++;
                start_cyc = cyc;
            end else if (recGPIO_OUT[31:29] == 3'b000) begin
                n_read++;
                req_mux  = recGPIO_OUT[24];
                req_addr = recGPIO_OUT[7:0];
                echo_at  = cyc + (stale_mode ? 9 : 4);
                if (stale_mode) echo = pack(1'b0, 8'd0, 10'h155);
            end else begin
                other_w.push_back(recGPIO_OUT);
                other_c.push_back(cyc);
            end
        end
        prev_strobe = recCsrStrobe;
        if (cyc == echo_at) echo = pack(req_mux, req_addr, sum_of(int'(req_addr), int'(req_mux)));
        recCsr = {busy_en && cyc >= start_cyc + 2 && cyc < start_cyc + 52, echo[30:0]};
    end

    always @(negedge sysClk) begin
        if (sysResetN && scanValid && scanReady) begin
            checks++;
            if (exp_data.size() == 0) begin
                failures++;
                $display("FAIL beat_unexpected idx=%0d data=%h last=%b", beats, scanData, scanLast);
            end else begin
                logic [18:0] ed;
                bit el;
                ed = exp_data.pop_front();
                el = exp_last.pop_front();
                if (scanData !== ed || scanLast !== el) begin
                    failures++;
                    $display("FAIL beat idx=%0d data=%h last=%b expected data=%h last=%b", beats, scanData, scanLast, ed, el);
                end
            end
            beats++;
        end
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge sysClk);
            #1;
        end
    endtask

    task automatic check(string nm, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, act, expv);
        end
    endtask

    task automatic check_zero(string nm);
        check({nm, "_strobe"}, 32'(recCsrStrobe), 0);
        check({nm, "_recword"}, recGPIO_OUT, 0);
        check({nm, "_status"}, sysStatus, 0);
        check({nm, "_valid"}, 32'(scanValid), 0);
        check({nm, "_data"}, 32'(scanData), 0);
        check({nm, "_last"}, 32'(scanLast), 0);
    endtask

    task automatic host_cmd(logic [31:0] w);
        sysCsrStrobe = 1'b1;
        sysGPIO_OUT  = w;
        step();
        sysCsrStrobe = 1'b0;
        sysGPIO_OUT  = '0;
    endtask

    task automatic wait_idle(int lim, output int n);
        n = 0;
        while (sysStatus[31] && n < lim) begin
            step();
            n++;
        end
    endtask

    task automatic wait_valid(string nm);
        int n = 0;
        while (!scanValid && n < 300) begin
            step();
            n++;
        end
        check({nm, "_valid"}, 32'(scanValid), 1);
    endtask

    task automatic take_beat(string nm);
        wait_valid(nm);
        scanReady = 1'b1;
        step();
        scanReady = 1'b0;
    endtask

    task automatic push_scan();
        for (int a = 0; a < 200; a++)
            for (int m = 0; m < 2; m++) begin
                exp_data.push_back({1'(m), 8'(a), sum_of(a, m)});
                exp_last.push_back(a == 199 && m == 1);
            end
    endtask

    task automatic run_full_scan(string nm);
        int n, s0, r0, b0;
        s0 = n_start;
        r0 = n_read;
        b0 = beats;
        push_scan();
        scanReady = 1'b1;
        host_cmd(START);
        wait_idle(10000, n);
        scanReady = 1'b0;
        check({nm, "_busy"}, 32'(sysStatus[31]), 0);
        check({nm, "_done"}, 32'(sysStatus[30]), 1);
        check({nm, "_timeout"}, 32'(sysStatus[29]), 0);
        check({nm, "_beats"}, beats - b0, 400);
        check({nm, "_start_strobes"}, n_start - s0, 1);
        check({nm, "_read_strobes"}, n_read - r0, 400);
        check({nm, "_b2b_strobes"}, n_b2b, 0);
        check({nm, "_left_in_queue"}, exp_data.size(), 0);
        exp_data.delete();
        exp_last.delete();
    endtask

    initial begin
        int n, s0, r0, b0;
        sysResetN = 1'b0;
        sysCsrStrobe = 1'b0;
        sysGPIO_OUT = '0;
        scanReady = 1'b0;
        step(3);
        check_zero("in_reset");
        sysResetN = 1'b1;
        step(2);
        check_zero("after_reset");

        run_full_scan("scan_normal");
        stale_mode = 1'b1;
        run_full_scan("scan_stale");
        stale_mode = 1'b0;

        busy_en = 1'b0;
        r0 = n_read;
        b0 = beats;
        host_cmd(START);
        wait_idle(300, n);
        check("timeout_cycles", n, 65);
        check("timeout_err", 32'(sysStatus[29]), 1);
        check("timeout_done", 32'(sysStatus[30]), 0);
        check("timeout_beats", beats - b0, 0);
        check("timeout_reads", n_read - r0, 0);
        busy_en = 1'b1;

        push_scan();
        b0 = beats;
        host_cmd(START);
        check("start_clears_timeout", 32'(sysStatus[29]), 0);
        check("start_busy", 32'(sysStatus[31]), 1);
        repeat (7) take_beat("pre_stall");
        wait_valid("stall");
        s0 = n_strobes;
        step(50);
        host_cmd(START);
        step(49);
        check("stall_data", 32'(scanData), 32'({1'b1, 8'd3, sum_of(3, 1)}));
        check("stall_valid", 32'(scanValid), 1);
        check("stall_strobes", n_strobes - s0, 0);
        repeat (3) take_beat("post_stall");
        wait_valid("beat10");
        host_cmd(ABORT);
        check("abort_busy", 32'(sysStatus[31]), 0);
        check("abort_valid", 32'(scanValid), 0);
        check("abort_done", 32'(sysStatus[30]), 0);
        check("abort_beats", beats - b0, 10);
        exp_data.delete();
        exp_last.delete();
        s0 = n_start;
        host_cmd(START | ABORT);
        step(3);
        check("start_abort_busy", 32'(sysStatus[31]), 0);
        check("start_abort_strobes", n_start - s0, 0);

        push_scan();
        host_cmd(START);
        repeat (3) take_beat("pre_reset");
        step(3);
        check("req_word", recGPIO_OUT, 32'h0100_0001);
        sysResetN = 1'b0;
        #1;
        check_zero("async_reset");
        step();
        sysResetN = 1'b1;
        exp_data.delete();
        exp_last.delete();
        step(2);
        run_full_scan("scan_after_reset");

`ifdef COINCIDENCE_SCAN_PEAK_EN
        peak_mode = 1'b1;
        other_w.delete();
        other_c.delete();
        host_cmd(32'h2000_0005);
        run_full_scan("scan_peak");
        check("peak_valid", 32'(sysStatus[28]), 1);
        check("peak_addr", 32'(sysStatus[7:0]), 42);
        check("peak_strobes", other_w.size(), 2);
        if (other_w.size() == 2) begin
            check("set_coinc_word", other_w[0] & 32'hE000_00FF, 32'h4000_002A);
            check("realign_word", other_w[1], 32'h2000_0000);
            check("realign_gap", other_c[1] - other_c[0], 3);
        end
`else
        check("no_peak_valid", 32'(sysStatus[28]), 0);
        check("no_peak_addr", 32'(sysStatus[7:0]), 0);
        check("no_special_strobes", other_w.size(), 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
